// File: rtl/frog_river_ctrl_if.sv
// Bus between the log-movement stage / input decoder and the frog controller,
// plus the frog state fanned out to the renderer and HUD.
interface frog_river_ctrl_if #(
  parameter int unsigned NUM_LANES = 4
);
  logic [10*NUM_LANES-1:0] log_x_flat;
  logic                    log_step;
  logic                    move_up;
  logic                    move_down;
  logic                    move_left;
  logic                    move_right;
  logic [9:0]              frog_x;
  logic [3:0]              frog_row;
  logic [1:0]              lives;
  logic [7:0]              score;
  logic                    dying;
  logic                    game_over;

  modport master (
    output log_x_flat, log_step, move_up, move_down, move_left, move_right,
    input  frog_x, frog_row, lives, score, dying, game_over
  );

  modport slave (
    input  log_x_flat, log_step, move_up, move_down, move_left, move_right,
    output frog_x, frog_row, lives, score, dying, game_over
  );
endinterface

// File: rtl/frog_river_ctrl.sv
// Frog position, log riding, drowning and the death/respawn/win sequence,
// with lives and score for the HUD.
module frog_river_ctrl #(
  parameter int unsigned BLOCK        = 32,
  parameter int unsigned LOG_WIDTH    = 96,
  parameter int unsigned LOG_SPEED    = 4,
  parameter int unsigned SCREEN_WIDTH = 320,
  parameter int unsigned NUM_LANES    = 4,
  parameter int unsigned RIVER_FIRST  = 1,
  parameter int unsigned START_X      = 128,
  parameter int unsigned START_ROW    = 9,
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned DEATH_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  frog_river_ctrl_if.slave   bus
);
  localparam int unsigned X_W      = 10;
  localparam int unsigned ROW_W    = 4;
  localparam int unsigned SUM_W    = 11;
  localparam int unsigned CNT_W    = $clog2(DEATH_CYCLES);
  localparam int unsigned ROW_LAST = 9;

  localparam logic [1:0] ST_ALIVE = 2'd0;
  localparam logic [1:0] ST_DYING = 2'd1;
  localparam logic [1:0] ST_WIN   = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [1:0]       lives_q, lives_d;
  logic [7:0]       score_q, score_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dying_q, dying_d;
  logic             over_q, over_d;

  logic signed [9:0]       sel_log;
  logic                    in_river;
  logic signed [SUM_W-1:0] log_lo, log_hi, frog_c;
  logic                    on_log;
  logic [SUM_W-1:0]        carry_x;
  logic                    carry_off;
  logic [1:0]              lives_dec;

  // Pick the log of the lane the frog currently stands in
  always_comb begin
    sel_log  = '0;
    in_river = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (row_q == ROW_W'(RIVER_FIRST + k)) begin
        in_river = 1'b1;
        sel_log  = bus.log_x_flat[10*k +: 10];
      end
    end
  end

  // Frog centre must lie within the log span; log edge may be negative
  assign log_lo    = {sel_log[9], sel_log};
  assign log_hi    = log_lo + $signed(SUM_W'(LOG_WIDTH - 1));
  assign frog_c    = $signed({1'b0, x_q} + SUM_W'(BLOCK / 2));
  assign on_log    = in_river && (log_lo <= frog_c) && (frog_c <= log_hi);
  assign carry_x   = {1'b0, x_q} + SUM_W'(LOG_SPEED);
  assign carry_off = (carry_x + SUM_W'(BLOCK)) > SUM_W'(SCREEN_WIDTH);
  assign lives_dec = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    row_d   = row_q;
    lives_d = lives_q;
    score_d = score_q;
    cnt_d   = cnt_q;
    dying_d = dying_q;
    over_d  = over_q;
    case (state_q)
      ST_ALIVE: begin
        if ((in_river && !on_log) || (in_river && bus.log_step && carry_off)) begin
          state_d = ST_DYING;
          lives_d = lives_dec;
          cnt_d   = '0;
          dying_d = 1'b1;
        end else if (in_river && bus.log_step) begin
          x_d = carry_x[X_W-1:0];
        end else if (bus.move_up) begin
          if (row_q != '0) row_d = row_q - ROW_W'(1);
          if (row_q == ROW_W'(1)) state_d = ST_WIN;
        end else if (bus.move_down) begin
          if (row_q < ROW_W'(ROW_LAST)) row_d = row_q + ROW_W'(1);
        end else if (bus.move_left) begin
          x_d = (x_q < X_W'(BLOCK)) ? '0 : x_q - X_W'(BLOCK);
        end else if (bus.move_right) begin
          x_d = (x_q >= X_W'(SCREEN_WIDTH - 2*BLOCK)) ? X_W'(SCREEN_WIDTH - BLOCK)
                                                      : x_q + X_W'(BLOCK);
        end
      end
      ST_DYING: begin
        if (cnt_q == CNT_W'(DEATH_CYCLES - 1)) begin
          dying_d = 1'b0;
          if (lives_q == 2'd0) begin
            state_d = ST_OVER;
            over_d  = 1'b1;
          end else begin
            state_d = ST_ALIVE;
            x_d     = X_W'(START_X);
            row_d   = ROW_W'(START_ROW);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WIN: begin
        if (score_q != 8'hFF) score_d = score_q + 8'd1;
        state_d = ST_ALIVE;
        x_d     = X_W'(START_X);
        row_d   = ROW_W'(START_ROW);
      end
      ST_OVER: ;
      default: state_d = ST_ALIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ALIVE;
      x_q     <= X_W'(START_X);
      row_q   <= ROW_W'(START_ROW);
      lives_q <= 2'(LIVES_INIT);
      score_q <= '0;
      cnt_q   <= '0;
      dying_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      row_q   <= row_d;
      lives_q <= lives_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
      dying_q <= dying_d;
      over_q  <= over_d;
    end
  end

  assign bus.frog_x    = x_q;
  assign bus.frog_row  = row_q;
  assign bus.lives     = lives_q;
  assign bus.score     = score_q;
  assign bus.dying     = dying_q;
  assign bus.game_over = over_q;
endmodule

// File: tb/tb_frog_river_ctrl.sv
// Directed bench for frog_river_ctrl with a cycle-level game model and
// hand-computed spot checks.
module tb_frog_river_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frog_river_ctrl_if #(.NUM_LANES(4)) bus();

  frog_river_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: mode 0 playing, 1 sinking, 2 goal reached, 3 over
  localparam int PLAY = 0, SINK = 1, GOAL = 2, OVER = 3;
  int m_x, m_row, m_lives, m_score, m_mode, m_timer;
  bit m_valid = 1'b0;

  function automatic int lane_x(input int k);
    logic signed [9:0] v;
    v = bus.log_x_flat[10*k +: 10];
    return int'(v);
  endfunction

  function automatic void m_die();
    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
    m_mode  = SINK;
    m_timer = 16;
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_x = 128; m_row = 9; m_lives = 3; m_score = 0; m_mode = PLAY; m_timer = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_mode)
        PLAY: begin
          bit river, on;
          int lx, c;
          river = (m_row >= 1) && (m_row <= 4);
          on = 1'b0;
          if (river) begin
            lx = lane_x(m_row - 1);
            c  = m_x + 16;
            on = (lx <= c) && (c <= lx + 95);
          end
          if (river && !on) m_die();
          else if (river && bus.log_step) begin
            if (m_x + 4 + 32 > 320) m_die();
            else m_x = m_x + 4;
          end else if (bus.move_up) begin
            m_row = m_row - 1;
            if (m_row == 0) m_mode = GOAL;
          end else if (bus.move_down) m_row = (m_row == 9) ? 9 : m_row + 1;
          else if (bus.move_left)  m_x = (m_x - 32 < 0) ? 0 : m_x - 32;
          else if (bus.move_right) m_x = (m_x + 32 > 288) ? 288 : m_x + 32;
        end
        SINK: begin
          m_timer = m_timer - 1;
          if (m_timer == 0) begin
            if (m_lives == 0) m_mode = OVER;
            else begin m_mode = PLAY; m_x = 128; m_row = 9; end
          end
        end
        GOAL: begin
          m_score = (m_score == 255) ? 255 : m_score + 1;
          m_mode = PLAY; m_x = 128; m_row = 9;
        end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("model_frog_x",    int'(bus.frog_x),    m_x);
      chk("model_frog_row",  int'(bus.frog_row),  m_row);
      chk("model_lives",     int'(bus.lives),     m_lives);
      chk("model_score",     int'(bus.score),     m_score);
      chk("model_dying",     int'(bus.dying),     int'(m_mode == SINK));
      chk("model_game_over", int'(bus.game_over), int'(m_mode == OVER));
    end
  end

  task automatic cyc(input bit u, input bit d, input bit l, input bit r, input bit s);
    bus.move_up = u; bus.move_down = d; bus.move_left = l; bus.move_right = r;
    bus.log_step = s;
    @(negedge clk);
    bus.move_up = 0; bus.move_down = 0; bus.move_left = 0; bus.move_right = 0;
    bus.log_step = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_log(input int k, input int v);
    bus.log_x_flat[10*k +: 10] = 10'(v);
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < 4; k++) set_log(k, v);
  endtask

  initial begin
    bus.move_up = 0; bus.move_down = 0; bus.move_left = 0; bus.move_right = 0;
    bus.log_step = 0;
    set_all(-96);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("rst_x", int'(bus.frog_x), 128);
    chk("rst_row", int'(bus.frog_row), 9);
    chk("rst_lives", int'(bus.lives), 3);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_dying", int'(bus.dying), 0);
    chk("rst_over", int'(bus.game_over), 0);

    // Walk into an empty river row and drown
    repeat (5) cyc(1, 0, 0, 0, 0);
    chk("walk_row4", int'(bus.frog_row), 4);
    chk("walk_alive", int'(bus.dying), 0);
    idle(1);
    chk("drown_dying", int'(bus.dying), 1);
    chk("drown_lives", int'(bus.lives), 2);
    idle(15);
    chk("drown_still", int'(bus.dying), 1);
    idle(1);
    chk("respawn_x", int'(bus.frog_x), 128);
    chk("respawn_row", int'(bus.frog_row), 9);
    chk("respawn_dying", int'(bus.dying), 0);

    // Ride a log in lane 3; moves during log_step are dropped
    do_reset();
    set_log(3, 112);
    repeat (5) cyc(1, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      set_log(3, 112 + 4*i);
      cyc(0, 0, 0, 0, 1);
    end
    chk("ride_x", int'(bus.frog_x), 140);
    chk("ride_dying", int'(bus.dying), 0);
    set_log(3, 128);
    cyc(1, 0, 0, 0, 1);
    chk("ride_drop_x", int'(bus.frog_x), 144);
    chk("ride_drop_row", int'(bus.frog_row), 4);
    idle(2);
    chk("ride_idle", int'(bus.dying), 0);

    // Carried off the right edge
    do_reset();
    repeat (5) cyc(0, 0, 0, 1, 0);
    set_log(3, 272);
    repeat (5) cyc(1, 0, 0, 0, 0);
    chk("edge_x", int'(bus.frog_x), 288);
    set_log(3, 276);
    cyc(0, 0, 0, 0, 1);
    chk("edge_dying", int'(bus.dying), 1);
    chk("edge_lives", int'(bus.lives), 2);
    chk("edge_x_hold", int'(bus.frog_x), 288);
    idle(16);

    // Horizontal clamps and move priority
    set_all(-96);
    do_reset();
    repeat (6) cyc(0, 0, 0, 1, 0);
    chk("clamp_right", int'(bus.frog_x), 288);
    do_reset();
    repeat (6) cyc(0, 0, 1, 0, 0);
    chk("clamp_left", int'(bus.frog_x), 0);
    cyc(1, 0, 1, 0, 0);
    chk("prio_row", int'(bus.frog_row), 8);
    chk("prio_x", int'(bus.frog_x), 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("clamp_down", int'(bus.frog_row), 9);

    // Goal crossings and score saturation
    do_reset();
    set_all(112);
    for (int w = 0; w < 256; w++) begin
      repeat (9) cyc(1, 0, 0, 0, 0);
      if (w == 0) chk("win_row0", int'(bus.frog_row), 0);
      idle(1);
      if (w == 0) begin
        chk("win_score", int'(bus.score), 1);
        chk("win_x", int'(bus.frog_x), 128);
        chk("win_row", int'(bus.frog_row), 9);
      end
    end
    chk("score_sat", int'(bus.score), 255);

    // Three drownings end the game
    set_all(-96);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      repeat (5) cyc(1, 0, 0, 0, 0);
      idle(17);
    end
    chk("over_flag", int'(bus.game_over), 1);
    chk("over_lives", int'(bus.lives), 0);
    chk("over_dying", int'(bus.dying), 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    chk("over_row_hold", int'(bus.frog_row), 4);
    chk("over_x_hold", int'(bus.frog_x), 128);
    do_reset();
    chk("over_reset", int'(bus.game_over), 0);

    // Reset in the middle of the third death
    for (int i = 0; i < 2; i++) begin
      repeat (5) cyc(1, 0, 0, 0, 0);
      idle(17);
    end
    repeat (5) cyc(1, 0, 0, 0, 0);
    idle(6);
    chk("mid_dying", int'(bus.dying), 1);
    chk("mid_lives", int'(bus.lives), 0);
    do_reset();
    chk("mid_rst_lives", int'(bus.lives), 3);
    chk("mid_rst_dying", int'(bus.dying), 0);
    chk("mid_rst_over", int'(bus.game_over), 0);
    chk("mid_rst_row", int'(bus.frog_row), 9);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
